// File: rtl/vcortex_mem_arbiter.sv
// vcortex_mem_arbiter: shares the sys_mem master port between the line-buffer
// fetch agent (port 0, read-only) and the frame writer (port 1, read/write).
// Bounded-burst round-robin with an urgent override for port 0, and an
// in-order tag FIFO that routes read returns back to the issuing port.
// Optional: define VCORTEX_ARB_STATS_EN to add the gnt0/gnt1/urgent counters.
module vcortex_mem_arbiter #(
    parameter int unsigned SYS_MEM_DATA_W = 32,
    parameter int unsigned SYS_MEM_ADDR_W = 27,
    parameter int unsigned LBFFR_OCC_W    = 11,
    parameter int unsigned URGENT_THRESH  = 256,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned RD_TAG_DEPTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lbf_rden,
    input  logic [SYS_MEM_ADDR_W-1:0] lbf_addr,
    input  logic [LBFFR_OCC_W-1:0]    lbf_occ,
    output logic                      lbf_wait,
    output logic                      lbf_rd_valid,
    output logic [SYS_MEM_DATA_W-1:0] lbf_rdata,
    input  logic                      fw_wren,
    input  logic                      fw_rden,
    input  logic [SYS_MEM_ADDR_W-1:0] fw_addr,
    input  logic [SYS_MEM_DATA_W-1:0] fw_wdata,
    output logic                      fw_wait,
    output logic                      fw_rd_valid,
    output logic [SYS_MEM_DATA_W-1:0] fw_rdata,
    input  logic                      sys_mem_wait,
    output logic                      sys_mem_wren,
    output logic                      sys_mem_rden,
    output logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr,
    output logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata,
    input  logic                      sys_mem_rd_valid,
    input  logic [SYS_MEM_DATA_W-1:0] sys_mem_rdata,
    output logic                      arb_err
`ifdef VCORTEX_ARB_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [31:0]               gnt0_cnt,
    output logic [31:0]               gnt1_cnt,
    output logic [31:0]               urgent_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(RD_TAG_DEPTH);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [PTR_W:0]       TAG_FULL   = (PTR_W + 1)'(RD_TAG_DEPTH);
    localparam logic [CNT_W-1:0]     BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [LBFFR_OCC_W:0] URG_TH     = (LBFFR_OCC_W + 1)'(URGENT_THRESH);

    typedef enum logic [1:0] {ST_IDLE, ST_GNT0, ST_GNT1} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      last_q, last_d;   // 1 = port 1 was granted last
    logic [RD_TAG_DEPTH-1:0]   tag_mem_q;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]            tag_cnt_q;
    logic                      err_q;

    logic req0, req1, urgent, tag_full, tag_empty;
    logic cmd_rd, cmd_wr, cmd, gnt_wait, accept, pending, burst_last, urg_pre;
    logic push, pop_ok, head;

    assign req0       = lbf_rden;
    assign req1       = fw_wren | fw_rden;
    assign urgent     = {1'b0, lbf_occ} < URG_TH;
    assign tag_full   = (tag_cnt_q == TAG_FULL);
    assign tag_empty  = (tag_cnt_q == '0);
    assign burst_last = (cnt_q == BURST_LAST);

    // Command mux: the granted port drives sys_mem, everything else idles
    always_comb begin
        cmd_rd        = 1'b0;
        cmd_wr        = 1'b0;
        sys_mem_addr  = '0;
        sys_mem_wdata = '0;
        case (state_q)
            ST_GNT0: begin
                cmd_rd       = lbf_rden;
                sys_mem_addr = lbf_addr;
            end
            ST_GNT1: begin
                cmd_rd        = fw_rden;
                cmd_wr        = fw_wren;
                sys_mem_addr  = fw_addr;
                sys_mem_wdata = fw_wdata;
            end
            default: ;
        endcase
    end

    assign gnt_wait = sys_mem_wait | (cmd_rd & tag_full);
    assign cmd      = cmd_rd | cmd_wr;
    assign accept   = cmd & ~gnt_wait;
    assign pending  = cmd & gnt_wait;

    // A read stalled only by a full tag FIFO is withheld from the slave so it
    // cannot be taken there without a tag to route its data back.
    assign sys_mem_rden = cmd_rd & ~tag_full;
    assign sys_mem_wren = cmd_wr;
    assign lbf_wait     = (state_q == ST_GNT0) ? gnt_wait : 1'b1;
    assign fw_wait      = (state_q == ST_GNT1) ? gnt_wait : 1'b1;

    // Grant decision; switching only happens with no unaccepted command held
    always_comb begin
        state_d = state_q;
        urg_pre = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && (urgent || !req1 || last_q)) state_d = ST_GNT0;
                else if (req1)                           state_d = ST_GNT1;
            end
            ST_GNT0: begin
                if (accept && burst_last && req1) state_d = ST_GNT1;
                else if (!req0)                   state_d = req1 ? ST_GNT1 : ST_IDLE;
            end
            ST_GNT1: begin
                if (accept && burst_last && req0) state_d = ST_GNT0;
                else if (!req1)                   state_d = req0 ? ST_GNT0 : ST_IDLE;
                else if (req0 && urgent && !pending) begin
                    state_d = ST_GNT0;
                    urg_pre = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Burst count saturates at MAX_BURST-1 so a yield still fires when
        // the other port only starts requesting after a long solo run.
        cnt_d = cnt_q;
        if (state_d != state_q)         cnt_d = '0;
        else if (accept && !burst_last) cnt_d = cnt_q + CNT_W'(1);
        last_d = last_q;
        if (state_d == ST_GNT0)      last_d = 1'b0;
        else if (state_d == ST_GNT1) last_d = 1'b1;
    end

    // Arbiter FSM state, burst counter and last-granted port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign push   = accept & cmd_rd;
    assign pop_ok = sys_mem_rd_valid & ~tag_empty;
    assign head   = tag_mem_q[rd_ptr_q];

    // Tag FIFO of issuing port ids plus the sticky protocol error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                tag_mem_q[wr_ptr_q] <= (state_q == ST_GNT1);
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop_ok})
                2'b10:   tag_cnt_q <= tag_cnt_q + (PTR_W + 1)'(1);
                2'b01:   tag_cnt_q <= tag_cnt_q - (PTR_W + 1)'(1);
                default: ;
            endcase
            if ((sys_mem_rd_valid && tag_empty) || (push && tag_full)) err_q <= 1'b1;
        end
    end

    assign arb_err      = err_q;
    assign lbf_rdata    = sys_mem_rdata;
    assign fw_rdata     = sys_mem_rdata;
    assign lbf_rd_valid = pop_ok & ~head;
    assign fw_rd_valid  = pop_ok & head;

`ifdef VCORTEX_ARB_STATS_EN
    logic [31:0] gnt0_cnt_q, gnt1_cnt_q, urg_cnt_q;

    // Saturating accept counters per port and urgent-preempt counter
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
            urg_cnt_q  <= '0;
        end else begin
            if (accept && state_q == ST_GNT0 && gnt0_cnt_q != '1) gnt0_cnt_q <= gnt0_cnt_q + 32'd1;
            if (accept && state_q == ST_GNT1 && gnt1_cnt_q != '1) gnt1_cnt_q <= gnt1_cnt_q + 32'd1;
            if (urg_pre && urg_cnt_q != '1)                       urg_cnt_q  <= urg_cnt_q + 32'd1;
        end
    end

    assign gnt0_cnt   = gnt0_cnt_q;
    assign gnt1_cnt   = gnt1_cnt_q;
    assign urgent_cnt = urg_cnt_q;
`endif

endmodule

// File: tb/tb_vcortex_mem_arbiter.sv
// Testbench for vcortex_mem_arbiter: per-cycle reference model plus directed
// scenarios with literal expectations.
module tb_vcortex_mem_arbiter;

    localparam int AW    = 27;
    localparam int DW    = 32;
    localparam int OW    = 11;
    localparam int MAXB  = 16;
    localparam int DEPTH = 32;
    localparam int THR   = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lbf_rden, lbf_wait, lbf_rd_valid;
    logic [AW-1:0] lbf_addr;
    logic [OW-1:0] lbf_occ;
    logic [DW-1:0] lbf_rdata;
    logic          fw_wren, fw_rden, fw_wait, fw_rd_valid;
    logic [AW-1:0] fw_addr;
    logic [DW-1:0] fw_wdata, fw_rdata;
    logic          sys_mem_wait, sys_mem_wren, sys_mem_rden, sys_mem_rd_valid, arb_err;
    logic [AW-1:0] sys_mem_addr;
    logic [DW-1:0] sys_mem_wdata, sys_mem_rdata;
`ifdef VCORTEX_ARB_STATS_EN
    logic          stats_clr = 1'b0;
    logic [31:0]   gnt0_cnt, gnt1_cnt, urgent_cnt;
`endif

    // slave return path: manual (directed) or automatic (streaming)
    logic          auto_ret = 1'b0, auto_rv = 1'b0, man_rv = 1'b0;
    logic [DW-1:0] auto_rdata = '0, man_rdata = '0;
    int            outst = 0;
    assign sys_mem_rd_valid = auto_ret ? auto_rv : man_rv;
    assign sys_mem_rdata    = auto_ret ? auto_rdata : man_rdata;

    vcortex_mem_arbiter #(
        .SYS_MEM_DATA_W(DW), .SYS_MEM_ADDR_W(AW), .LBFFR_OCC_W(OW),
        .URGENT_THRESH(THR), .MAX_BURST(MAXB), .RD_TAG_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lbf_rden(lbf_rden), .lbf_addr(lbf_addr), .lbf_occ(lbf_occ), .lbf_wait(lbf_wait),
        .lbf_rd_valid(lbf_rd_valid), .lbf_rdata(lbf_rdata),
        .fw_wren(fw_wren), .fw_rden(fw_rden), .fw_addr(fw_addr), .fw_wdata(fw_wdata),
        .fw_wait(fw_wait), .fw_rd_valid(fw_rd_valid), .fw_rdata(fw_rdata),
        .sys_mem_wait(sys_mem_wait), .sys_mem_wren(sys_mem_wren), .sys_mem_rden(sys_mem_rden),
        .sys_mem_addr(sys_mem_addr), .sys_mem_wdata(sys_mem_wdata),
        .sys_mem_rd_valid(sys_mem_rd_valid), .sys_mem_rdata(sys_mem_rdata),
        .arb_err(arb_err)
`ifdef VCORTEX_ARB_STATS_EN
        , .stats_clr(stats_clr), .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .urgent_cnt(urgent_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_owner = -1;   // -1 none, else port holding the bus
    int   m_last  = 1;
    int   m_burst = 0;
    int   m_tags[$];
    bit   m_err   = 1'b0;
    bit   m_valid = 1'b0;
    int   m_acc0 = 0, m_acc1 = 0, m_urg = 0;
    bit   m_rd, m_wr, m_full, m_blk, m_took, m_lw, m_fw, m_lrv, m_frv, m_r0, m_r1, m_ur, m_self, m_oth;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    int   m_nxt;

    always @(negedge clk) begin
        if (m_valid) begin
            m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wd = '0;
            m_full = (m_tags.size() == DEPTH);
            if (m_owner == 0) begin
                m_rd = lbf_rden; m_addr = lbf_addr;
            end else if (m_owner == 1) begin
                m_rd = fw_rden; m_wr = fw_wren; m_addr = fw_addr; m_wd = fw_wdata;
            end
            m_blk  = sys_mem_wait || (m_rd && m_full);
            m_lw   = (m_owner == 0) ? m_blk : 1'b1;
            m_fw   = (m_owner == 1) ? m_blk : 1'b1;
            m_took = (m_rd || m_wr) && !m_blk;
            m_lrv  = sys_mem_rd_valid && m_tags.size() > 0 && m_tags[0] == 0;
            m_frv  = sys_mem_rd_valid && m_tags.size() > 0 && m_tags[0] == 1;
            check("ctrl{wr,rd,lw,fw,lrv,frv,err}",
                  {sys_mem_wren, sys_mem_rden, lbf_wait, fw_wait, lbf_rd_valid, fw_rd_valid, arb_err},
                  {m_wr, m_rd && !m_full, m_lw, m_fw, m_lrv, m_frv, m_err});
            if (m_wr || (m_rd && !m_full)) check("sys_mem_addr", sys_mem_addr, m_addr);
            if (m_wr) check("sys_mem_wdata", sys_mem_wdata, m_wd);
            if (m_lrv) check("lbf_rdata", lbf_rdata, sys_mem_rdata);
            if (m_frv) check("fw_rdata", fw_rdata, sys_mem_rdata);
`ifdef VCORTEX_ARB_STATS_EN
            check("stats{g0,g1,urg}", {gnt0_cnt[20:0], gnt1_cnt[20:0], urgent_cnt[20:0]},
                  {21'(m_acc0), 21'(m_acc1), 21'(m_urg)});
`endif
        end
        if (!rst_n) begin
            m_owner = -1; m_last = 1; m_burst = 0; m_tags.delete(); m_err = 1'b0;
            m_acc0 = 0; m_acc1 = 0; m_urg = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_r0 = lbf_rden;
            m_r1 = fw_wren || fw_rden;
            m_ur = lbf_occ < THR;
            if (sys_mem_rd_valid) begin
                if (m_tags.size() == 0) m_err = 1'b1;
                else void'(m_tags.pop_front());
            end
            if (m_took && m_rd) begin
                if (m_tags.size() >= DEPTH) m_err = 1'b1;
                m_tags.push_back(m_owner);
            end
            if (m_took) begin
                if (m_owner == 0) m_acc0++; else m_acc1++;
            end
            m_nxt = m_owner;
            if (m_owner < 0) begin
                if (m_r0 && (m_ur || !m_r1 || m_last == 1)) m_nxt = 0;
                else if (m_r1) m_nxt = 1;
            end else begin
                m_self = (m_owner == 0) ? m_r0 : m_r1;
                m_oth  = (m_owner == 0) ? m_r1 : m_r0;
                if (m_took && m_burst == MAXB - 1 && m_oth) m_nxt = 1 - m_owner;
                else if (!m_self) m_nxt = m_oth ? 1 - m_owner : -1;
                else if (m_owner == 1 && m_r0 && m_ur && !((m_rd || m_wr) && m_blk)) begin
                    m_nxt = 0;
                    m_urg++;
                end
            end
            if (m_nxt != m_owner) m_burst = 0;
            else if (m_took && m_burst < MAXB - 1) m_burst++;
            if (m_nxt >= 0) m_last = m_nxt;
            m_owner = m_nxt;
`ifdef VCORTEX_ARB_STATS_EN
            if (stats_clr) begin m_acc0 = 0; m_acc1 = 0; m_urg = 0; end
`endif
        end
    end

    // ---------------- streaming slave ----------------
    always @(negedge clk) begin
        if (!rst_n) outst = 0;
        else outst = outst + ((sys_mem_rden && !sys_mem_wait) ? 1 : 0) - (sys_mem_rd_valid ? 1 : 0);
    end
    always @(posedge clk) begin
        #1;
        auto_rv    = auto_ret && (outst > 0);
        auto_rdata = $urandom;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lbf_rden = 1'b0; fw_wren = 1'b0; fw_rden = 1'b0; sys_mem_wait = 1'b0;
        man_rv = 1'b0; auto_ret = 1'b0; lbf_occ = 11'd1024;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic issue(input int port, input logic [AW-1:0] a);
        bit acc;
        acc = 1'b0;
        if (port == 0) begin lbf_rden = 1'b1; lbf_addr = a; end
        else begin fw_rden = 1'b1; fw_addr = a; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((port == 0) ? !lbf_wait : !fw_wait) begin acc = 1'b1; break; end
            tick();
        end
        check("issue_accepted", acc, 1'b1);
        tick();
        lbf_rden = 1'b0; fw_rden = 1'b0;
    endtask

    logic [DW-1:0] ret_tbl [4];
    logic [DW-1:0] got0 [$];
    logic [DW-1:0] got1 [$];
    int runs [8];
    int rport [8];
    int nruns, cur, len, dead, n;
    bit a0, a1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        lbf_addr = '0; fw_addr = '0; fw_wdata = '0;
        rst_n = 1'b0;
        lbf_rden = 1'b1; fw_rden = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset{wr,rd,lw,fw,lrv,frv,err}",
                  {sys_mem_wren, sys_mem_rden, lbf_wait, fw_wait, lbf_rd_valid, fw_rd_valid, arb_err},
                  7'b0011000);
            tick();
        end
        do_reset();

        // tag routing: reads 0,1,1,0 then returns A..D
        issue(0, 27'h10); issue(1, 27'h20); issue(1, 27'h30); issue(0, 27'h40);
        ret_tbl[0] = 32'hAAAA_0001; ret_tbl[1] = 32'hBBBB_0002;
        ret_tbl[2] = 32'hCCCC_0003; ret_tbl[3] = 32'hDDDD_0004;
        for (int k = 0; k < 4; k++) begin
            man_rv = 1'b1; man_rdata = ret_tbl[k];
            @(negedge clk);
            if (lbf_rd_valid) got0.push_back(lbf_rdata);
            if (fw_rd_valid)  got1.push_back(fw_rdata);
            tick();
        end
        man_rv = 1'b0;
        check("route_lbf_count", got0.size(), 2);
        check("route_fw_count", got1.size(), 2);
        check("route_lbf_0", got0[0], 32'hAAAA_0001);
        check("route_lbf_1", got0[1], 32'hDDDD_0004);
        check("route_fw_0", got1[0], 32'hBBBB_0002);
        check("route_fw_1", got1[1], 32'hCCCC_0003);
        check("route_no_err", arb_err, 1'b0);

        // round-robin streaming reads from both ports
        do_reset();
        auto_ret = 1'b1; lbf_addr = 27'h111; fw_addr = 27'h222;
        lbf_rden = 1'b1; fw_rden = 1'b1;
        nruns = 0; cur = -1; len = 0; dead = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a0 = sys_mem_rden && !lbf_wait;
            a1 = (sys_mem_rden || sys_mem_wren) && !fw_wait;
            if (a0 || a1) begin
                if (cur >= 0 && (a0 ? 0 : 1) != cur) begin
                    if (nruns < 8) begin runs[nruns] = len; rport[nruns] = cur; end
                    nruns++;
                    len = 0;
                end
                cur = a0 ? 0 : 1;
                len++;
            end else if (cur >= 0) dead++;
            tick();
        end
        lbf_rden = 1'b0; fw_rden = 1'b0;
        repeat (3) tick();
        auto_ret = 1'b0;
        check("rr_runs_ge4", nruns >= 4, 1'b1);
        check("rr_first_port", rport[0], 0);
        check("rr_alternate", rport[1], 1);
        for (int r = 0; r < 4; r++) check("rr_run_len", runs[r], MAXB);
        check("rr_dead_bound", dead <= nruns, 1'b1);

        // urgent preempt of a port-1 burst at cnt=5
        do_reset();
        fw_wren = 1'b1; fw_addr = 27'h300; fw_wdata = 32'h5555_0000; lbf_addr = 27'h4A4;
        n = 0;
        for (int i = 0; i < 50 && n < 5; i++) begin
            @(negedge clk);
            if (!fw_wait) n++;
            tick();
            if (n >= 1) lbf_rden = 1'b1;
        end
        check("urg_setup_accepts", n, 5);
        lbf_occ = 11'd100;
        @(negedge clk);
        check("urg_last_fw_accept{lw,fw}", {lbf_wait, fw_wait}, 2'b10);
        tick();
        @(negedge clk);
        check("urg_gnt0{rd,lw,fw}", {sys_mem_rden, lbf_wait, fw_wait}, 3'b101);
        check("urg_addr", sys_mem_addr, 27'h4A4);
`ifdef VCORTEX_ARB_STATS_EN
        check("urg_stat", urgent_cnt, 32'd1);
`endif
        tick();

        // wait hold: port-1 write stalled 10 cycles with port 0 urgent
        do_reset();
        sys_mem_wait = 1'b1; fw_wren = 1'b1; fw_addr = 27'h1234; fw_wdata = 32'hDEAD_BEEF;
        tick();
        lbf_rden = 1'b1; lbf_occ = 11'd100; lbf_addr = 27'h777;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold{wr,addr,wdata,lw,fw}", {sys_mem_wren, sys_mem_addr, sys_mem_wdata, lbf_wait, fw_wait},
                  {1'b1, 27'h1234, 32'hDEAD_BEEF, 1'b1, 1'b1});
            tick();
        end
        sys_mem_wait = 1'b0;
        @(negedge clk);
        check("hold_release_accept", fw_wait, 1'b0);
        tick();
        @(negedge clk);
        check("hold_then_gnt0{rd,lw,fw}", {sys_mem_rden, lbf_wait, fw_wait}, 3'b101);
        tick();

        // tag FIFO full, then underflow error
        do_reset();
        lbf_rden = 1'b1; lbf_addr = 27'h50;
        n = 0;
        for (int i = 0; i < 100 && n < DEPTH; i++) begin
            @(negedge clk);
            if (!lbf_wait) n++;
            tick();
        end
        check("full_accepts", n, DEPTH);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_stall{lw,rd}", {lbf_wait, sys_mem_rden}, 2'b10);
            tick();
        end
        lbf_rden = 1'b0;
        man_rv = 1'b1; man_rdata = 32'h1;
        repeat (DEPTH) tick();
        man_rv = 1'b0;
        @(negedge clk);
        check("drained_no_err", arb_err, 1'b0);
        tick();
        man_rv = 1'b1;
        tick();
        man_rv = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("underflow_err_sticky", arb_err, 1'b1);
        tick();

        // reset drops outstanding tags; the late return flags an error
        do_reset();
        @(negedge clk);
        check("err_cleared_by_reset", arb_err, 1'b0);
        tick();
        issue(0, 27'h60);
        do_reset();
        man_rv = 1'b1; man_rdata = 32'h2;
        tick();
        man_rv = 1'b0;
        @(negedge clk);
        check("dropped_tag_err", arb_err, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
